// File: rtl/reorder_buffer_if.sv
// Reorder buffer bundle: allocation, completion bus,
// operand lookup, commit and flush signals.
interface reorder_buffer_if #(
  parameter int ROB_ADD_W = 4,
  parameter int REG_ADD_W = 5,
  parameter int REG_DAT_W = 32
);
  logic                 en;
  logic [ROB_ADD_W-1:0] oAL_Qn;
  logic                 oAL_Full;
  logic                 iAL_En;
  logic [REG_ADD_W-1:0] iAL_Rd;
  logic                 iAL_Br;
  logic                 iCD_En;
  logic [ROB_ADD_W-1:0] iCD_Q;
  logic [REG_DAT_W-1:0] iCD_V;
  logic                 iCD_Mp;
  logic [ROB_ADD_W-1:0] iRD_Q1;
  logic [ROB_ADD_W-1:0] iRD_Q2;
  logic                 oRD_Rdy1;
  logic                 oRD_Rdy2;
  logic [REG_DAT_W-1:0] oRD_V1;
  logic [REG_DAT_W-1:0] oRD_V2;
  logic                 oRF_En;
  logic [REG_ADD_W-1:0] oRF_Rd;
  logic [ROB_ADD_W-1:0] oRF_Qd;
  logic [REG_DAT_W-1:0] oRF_Vd;
  logic                 oMp;
  logic [REG_DAT_W-1:0] oMpPc;

  modport slave (
    input  en, iAL_En, iAL_Rd, iAL_Br,
    input  iCD_En, iCD_Q, iCD_V, iCD_Mp,
    input  iRD_Q1, iRD_Q2,
    output oAL_Qn, oAL_Full,
    output oRD_Rdy1, oRD_Rdy2, oRD_V1, oRD_V2,
    output oRF_En, oRF_Rd, oRF_Qd, oRF_Vd,
    output oMp, oMpPc
  );

  modport master (
    output en, iAL_En, iAL_Rd, iAL_Br,
    output iCD_En, iCD_Q, iCD_V, iCD_Mp,
    output iRD_Q1, iRD_Q2,
    input  oAL_Qn, oAL_Full,
    input  oRD_Rdy1, oRD_Rdy2, oRD_V1, oRD_V2,
    input  oRF_En, oRF_Rd, oRF_Qd, oRF_Vd,
    input  oMp, oMpPc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags 1..DEPTH, tag 0 means
// "no pending producer"; in-order commit and flush.
module reorder_buffer #(
  parameter int ROB_ADD_W = 4,
  parameter int REG_ADD_W = 5,
  parameter int REG_DAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  reorder_buffer_if.slave   bus
);
  localparam int DEPTH = (1 << ROB_ADD_W) - 1;
  typedef logic [ROB_ADD_W-1:0] tag_t;
  localparam tag_t ONE  = tag_t'(1);
  localparam tag_t LAST = tag_t'(DEPTH);

  logic [DEPTH:0]       valid, ready, br, mp;
  logic [REG_ADD_W-1:0] rd  [0:DEPTH];
  logic [REG_DAT_W-1:0] val [0:DEPTH];
  tag_t                 head, tail, count;

  logic                 rf_en, mp_o;
  logic [REG_ADD_W-1:0] rf_rd;
  tag_t                 rf_qd;
  logic [REG_DAT_W-1:0] rf_vd, mp_pc;

  logic full, live, alloc, comp;
  logic commit, flush, wr;

  function automatic tag_t nxt(tag_t p);
    return (p == LAST) ? ONE : p + ONE;
  endfunction

  // Traffic seen while oMp is high predates the flush.
  assign full   = (count == LAST);
  assign live   = bus.en && !mp_o;
  assign alloc  = live && bus.iAL_En && !full;
  assign comp   = live && bus.iCD_En
               && (bus.iCD_Q != '0)
               && valid[bus.iCD_Q];
  assign commit = bus.en && valid[head]
               && ready[head];
  assign flush  = commit && br[head] && mp[head];
  assign wr     = commit && !br[head]
               && (rd[head] != '0);

  assign bus.oAL_Qn   = tail;
  assign bus.oAL_Full = full;
  assign bus.oRF_En   = rf_en;
  assign bus.oRF_Rd   = rf_rd;
  assign bus.oRF_Qd   = rf_qd;
  assign bus.oRF_Vd   = rf_vd;
  assign bus.oMp      = mp_o;
  assign bus.oMpPc    = mp_pc;

  always_comb begin
    bus.oRD_Rdy1 = 1'b0;
    bus.oRD_V1   = '0;
    bus.oRD_Rdy2 = 1'b0;
    bus.oRD_V2   = '0;
    if (bus.iRD_Q1 != '0 && valid[bus.iRD_Q1]) begin
      if (comp && bus.iCD_Q == bus.iRD_Q1) begin
        bus.oRD_Rdy1 = 1'b1;
        bus.oRD_V1   = bus.iCD_V;
      end else if (ready[bus.iRD_Q1]) begin
        bus.oRD_Rdy1 = 1'b1;
        bus.oRD_V1   = val[bus.iRD_Q1];
      end
    end
    if (bus.iRD_Q2 != '0 && valid[bus.iRD_Q2]) begin
      if (comp && bus.iCD_Q == bus.iRD_Q2) begin
        bus.oRD_Rdy2 = 1'b1;
        bus.oRD_V2   = bus.iCD_V;
      end else if (ready[bus.iRD_Q2]) begin
        bus.oRD_Rdy2 = 1'b1;
        bus.oRD_V2   = val[bus.iRD_Q2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      ready <= '0;
      br    <= '0;
      mp    <= '0;
      head  <= ONE;
      tail  <= ONE;
      count <= '0;
      rf_en <= 1'b0;
      rf_rd <= '0;
      rf_qd <= '0;
      rf_vd <= '0;
      mp_o  <= 1'b0;
      mp_pc <= '0;
    end else if (!bus.en) begin
      rf_en <= 1'b0;
      mp_o  <= 1'b0;
    end else begin
      rf_en <= wr;
      mp_o  <= flush;
      if (flush) begin
        valid <= '0;
        ready <= '0;
        head  <= ONE;
        tail  <= ONE;
        count <= '0;
        mp_pc <= val[head];
      end else begin
        if (alloc) begin
          valid[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          br[tail]    <= bus.iAL_Br;
          mp[tail]    <= 1'b0;
          rd[tail]    <= bus.iAL_Rd;
          tail        <= nxt(tail);
        end
        if (comp) begin
          ready[bus.iCD_Q] <= 1'b1;
          val[bus.iCD_Q]   <= bus.iCD_V;
          mp[bus.iCD_Q]    <= bus.iCD_Mp;
        end
        // Retire clears after completion so it wins.
        if (commit) begin
          valid[head] <= 1'b0;
          ready[head] <= 1'b0;
          head        <= nxt(head);
        end
        if (wr) begin
          rf_rd <= rd[head];
          rf_qd <= head;
          rf_vd <= val[head];
        end
        unique case ({alloc, commit})
          2'b10:   count <= count + ONE;
          2'b01:   count <= count - ONE;
          default: count <= count;
        endcase
      end
    end
  end
endmodule
